// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT peak detector.
// FFT_PEAK_NEIGHBOR_EN adds neighbour magnitudes to each peak slot.
package fft_pkg;

  localparam int FFT_SIZE = 2048;
  localparam int MAG_W    = 28;
  localparam int BIN_W    = 11;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FINISH  = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
`ifdef FFT_PEAK_NEIGHBOR_EN
    logic [MAG_W-1:0] mag_left;
    logic [MAG_W-1:0] mag_right;
`endif
  } peak_slot_t;

endpackage

// File: rtl/peak_sorted_insert.sv
// K-slot register array kept sorted by descending magnitude, with
// single-cycle clear, insert and read-by-rank.
module peak_sorted_insert
  import fft_pkg::*;
#(
  parameter int NUM_PEAKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             insert,
  input  logic [BIN_W-1:0] cand_bin,
  input  logic [MAG_W-1:0] cand_mag,
`ifdef FFT_PEAK_NEIGHBOR_EN
  input  logic [MAG_W-1:0] cand_mag_left,
  input  logic [MAG_W-1:0] cand_mag_right,
`endif
  input  logic [2:0]       rd_rank,
  output peak_slot_t       rd_slot,
  output logic [3:0]       slot_count
);

  peak_slot_t           slots [NUM_PEAKS];
  peak_slot_t           cand_v;
  logic [NUM_PEAKS-1:0] beats;

  always_comb begin
    cand_v       = '0;
    cand_v.valid = 1'b1;
    cand_v.bin   = cand_bin;
    cand_v.mag   = cand_mag;
`ifdef FFT_PEAK_NEIGHBOR_EN
    cand_v.mag_left  = cand_mag_left;
    cand_v.mag_right = cand_mag_right;
`endif
  end

  // Because the array is sorted, beats[] is a thermometer code: the first set
  // bit is the insertion point, everything below it shifts down one slot.
  for (genvar g = 0; g < NUM_PEAKS; g++) begin : g_slot
    peak_slot_t shifted;
    logic       beats_above;

    if (g == 0) begin : g_top
      assign shifted     = cand_v;
      assign beats_above = 1'b0;
    end else begin : g_rest
      assign shifted     = slots[g-1];
      assign beats_above = beats[g-1];
    end

    assign beats[g] = !slots[g].valid || (cand_mag > slots[g].mag);

    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        slots[g] <= '0;
      end else if (insert && beats[g]) begin
        slots[g] <= beats_above ? shifted : cand_v;
      end
    end
  end

  always_comb begin
    rd_slot = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      if (rd_rank == 3'(i)) rd_slot = slots[i];
    end
  end

  always_comb begin
    slot_count = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      slot_count = slot_count + {3'b000, slots[i].valid};
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Finds the K largest local-maximum peaks in one FFT magnitude frame and
// streams them out by rank. FFT_PEAK_NEIGHBOR_EN adds neighbour magnitudes.
//
// state      | meaning
// COLLECT    | ingest bins, test and insert candidates
// FINISH     | one cycle: frame_done pulse, peak_count latched
// REPORT     | stream slots by rank over valid/ready
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int               NUM_PEAKS = 4,
  parameter int               MIN_BIN   = 2,
  parameter int               MAX_BIN   = 1022,
  parameter logic [MAG_W-1:0] THRESHOLD = 28'd32768
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] mag_in,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             mag_valid,
  output logic             frame_done,
  output logic [3:0]       peak_count,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic [2:0]       peak_rank,
  output logic             peak_last,
`ifdef FFT_PEAK_NEIGHBOR_EN
  output logic [MAG_W-1:0] peak_mag_left,
  output logic [MAG_W-1:0] peak_mag_right,
`endif
  output logic             overrun
);

  localparam logic [BIN_W-1:0] MIN_B = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_BIN);

  logic [1:0]       state;
  logic [MAG_W-1:0] prev;
  logic [MAG_W-1:0] cur;
  logic [BIN_W-1:0] cur_bin;
  logic [1:0]       fill;
  logic [3:0]       peak_count_q;

  logic             accept;
  logic             frame_start;
  logic             frame_end;
  logic             is_cand;
  logic [2:0]       rd_rank;
  peak_slot_t       rd_slot;
  logic [3:0]       slot_count;

  assign accept      = mag_valid && (state == ST_COLLECT);
  assign frame_start = accept && (bin_in == '0);
  assign frame_end   = accept && (bin_in == LAST_BIN);

  // Strict rise on the left, non-strict on the right: a plateau reports its leftmost bin.
  assign is_cand = accept && !frame_start && (fill == 2'd2)
                   && (cur > prev) && (cur >= mag_in) && (cur >= THRESHOLD)
                   && (cur_bin >= MIN_B) && (cur_bin <= MAX_B);

  // Read port looks one rank ahead so the output registers load on the handshake.
  assign rd_rank = (state == ST_FINISH) ? 3'd0 : peak_rank + 3'd1;

  peak_sorted_insert #(
    .NUM_PEAKS (NUM_PEAKS)
  ) u_slots (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (frame_start),
    .insert         (is_cand),
    .cand_bin       (cur_bin),
    .cand_mag       (cur),
`ifdef FFT_PEAK_NEIGHBOR_EN
    .cand_mag_left  (prev),
    .cand_mag_right (mag_in),
`endif
    .rd_rank        (rd_rank),
    .rd_slot        (rd_slot),
    .slot_count     (slot_count)
  );

  assign frame_done = (state == ST_FINISH);
  assign peak_count = (state == ST_FINISH) ? slot_count : peak_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_COLLECT;
      prev         <= '0;
      cur          <= '0;
      cur_bin      <= '0;
      fill         <= '0;
      peak_count_q <= '0;
      peak_valid   <= 1'b0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      peak_rank    <= '0;
      peak_last    <= 1'b0;
`ifdef FFT_PEAK_NEIGHBOR_EN
      peak_mag_left  <= '0;
      peak_mag_right <= '0;
`endif
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        prev    <= frame_start ? '0 : cur;
        cur     <= mag_in;
        cur_bin <= bin_in;
        if (frame_start)        fill <= 2'd1;
        else if (fill != 2'd2)  fill <= fill + 2'd1;
      end

      if (mag_valid && (state != ST_COLLECT)) overrun <= 1'b1;

      case (state)
        ST_COLLECT: begin
          if (frame_end) state <= ST_FINISH;
        end
        ST_FINISH: begin
          peak_count_q <= slot_count;
          if (rd_slot.valid) begin
            state      <= ST_REPORT;
            peak_valid <= 1'b1;
            peak_rank  <= 3'd0;
            peak_bin   <= rd_slot.bin;
            peak_mag   <= rd_slot.mag;
            peak_last  <= (slot_count == 4'd1);
`ifdef FFT_PEAK_NEIGHBOR_EN
            peak_mag_left  <= rd_slot.mag_left;
            peak_mag_right <= rd_slot.mag_right;
`endif
          end else begin
            state <= ST_COLLECT;
          end
        end
        ST_REPORT: begin
          if (peak_ready) begin
            if (peak_last) begin
              peak_valid <= 1'b0;
              peak_last  <= 1'b0;
              state      <= ST_COLLECT;
            end else begin
              peak_rank <= rd_rank;
              peak_bin  <= rd_slot.bin;
              peak_mag  <= rd_slot.mag;
              peak_last <= ({1'b0, rd_rank} == (peak_count_q - 4'd1));
`ifdef FFT_PEAK_NEIGHBOR_EN
              peak_mag_left  <= rd_slot.mag_left;
              peak_mag_right <= rd_slot.mag_right;
`endif
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: a list-based peak model feeds
// expected counts/beats into queues that a negedge monitor consumes.
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int K      = 4;
  localparam int MINB   = 2;
  localparam int MAXB   = 1022;
  localparam int THRESH = 32768;

  typedef struct {
    int               bin;
    logic [MAG_W-1:0] mag;
    int               rank;
    bit               last;
    logic [MAG_W-1:0] left;
    logic [MAG_W-1:0] right;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [MAG_W-1:0] mag_in;
  logic [BIN_W-1:0] bin_in;
  logic             mag_valid;
  logic             frame_done;
  logic [3:0]       peak_count;
  logic             peak_valid;
  logic             peak_ready;
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;
  logic [2:0]       peak_rank;
  logic             peak_last;
`ifdef FFT_PEAK_NEIGHBOR_EN
  logic [MAG_W-1:0] peak_mag_left;
  logic [MAG_W-1:0] peak_mag_right;
`endif
  logic             overrun;

  int    n_vec = 0;
  int    n_err = 0;
  bit    hold_ready = 1'b0;
  int    exp_counts[$];
  beat_t exp_beats[$];
  logic [MAG_W-1:0] fm [FFT_SIZE];

  always #5 clk = ~clk;

  fft_peak_detect #(
    .NUM_PEAKS (K),
    .MIN_BIN   (MINB),
    .MAX_BIN   (MAXB),
    .THRESHOLD (28'd32768)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mag_in         (mag_in),
    .bin_in         (bin_in),
    .mag_valid      (mag_valid),
    .frame_done     (frame_done),
    .peak_count     (peak_count),
    .peak_valid     (peak_valid),
    .peak_ready     (peak_ready),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .peak_rank      (peak_rank),
    .peak_last      (peak_last),
`ifdef FFT_PEAK_NEIGHBOR_EN
    .peak_mag_left  (peak_mag_left),
    .peak_mag_right (peak_mag_right),
`endif
    .overrun        (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Reference: local maxima in the eligible window, ranked by magnitude,
  // ties by lower bin, truncated to K.
  function automatic void push_expect();
    int    cb[$];
    int    n;
    beat_t bt;
    for (int b = MINB; b <= MAXB; b++) begin
      if (fm[b] > fm[b-1] && fm[b] >= fm[b+1] && fm[b] >= THRESH) cb.push_back(b);
    end
    n = (cb.size() < K) ? cb.size() : K;
    exp_counts.push_back(n);
    for (int r = 0; r < n; r++) begin
      int best = 0;
      for (int j = 1; j < cb.size(); j++) begin
        if (fm[cb[j]] > fm[cb[best]]) best = j;
      end
      bt.bin   = cb[best];
      bt.mag   = fm[cb[best]];
      bt.rank  = r;
      bt.last  = (r == n - 1);
      bt.left  = fm[cb[best] - 1];
      bt.right = fm[cb[best] + 1];
      exp_beats.push_back(bt);
      cb.delete(best);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n_bins, input bit gaps);
    for (int b = 0; b < n_bins; b++) begin
      if (gaps && $urandom_range(0, 9) == 0) begin
        mag_valid = 1'b0;
        tick();
      end
      mag_valid = 1'b1;
      mag_in    = fm[b];
      bin_in    = BIN_W'(b);
      if (b == FFT_SIZE - 1) push_expect();
      tick();
    end
    mag_valid = 1'b0;
    if (n_bins == FFT_SIZE) begin
      check("frame_done_pulse", frame_done, 1);
      tick();
      check("frame_done_one_cycle", frame_done, 0);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (exp_counts.size() == 0 && exp_beats.size() == 0 && !peak_valid) done = 1'b1;
      else tick();
    end
    check("drain_complete", done, 1);
    tick();
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (peak_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic fill_const(input logic [MAG_W-1:0] v);
    for (int b = 0; b < FFT_SIZE; b++) fm[b] = v;
  endtask

  task automatic fill_random(input bit low_only);
    for (int b = 0; b < FFT_SIZE; b++) begin
      if (low_only)                         fm[b] = MAG_W'($urandom_range(0, 32767));
      else if ($urandom_range(0, 31) == 0)  fm[b] = 28'd60000;
      else if ($urandom_range(0, 15) == 0)  fm[b] = MAG_W'($urandom_range(32768, 200000));
      else                                  fm[b] = MAG_W'($urandom_range(0, 30000));
    end
  endtask

  // Output ready: random unless the stimulus forces a stall.
  initial begin
    peak_ready = 1'b0;
    forever begin
      tick();
      peak_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_stall = 1'b0;
    logic [43:0] prev_out   = '0;
    beat_t       bt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (frame_done) begin
          if (exp_counts.size() == 0) fail_now("unexpected_frame_done");
          else check("peak_count", peak_count, exp_counts.pop_front());
        end
        if (prev_stall)
          check("stall_stable", {peak_valid, peak_bin, peak_mag, peak_rank, peak_last}, prev_out);
        if (peak_valid && exp_beats.size() == 0) begin
          fail_now("spurious_peak_valid");
        end else if (peak_valid && peak_ready) begin
          bt = exp_beats.pop_front();
          check("peak_bin",  peak_bin,  bt.bin);
          check("peak_mag",  peak_mag,  bt.mag);
          check("peak_rank", peak_rank, bt.rank);
          check("peak_last", peak_last, bt.last);
`ifdef FFT_PEAK_NEIGHBOR_EN
          check("peak_mag_left",  peak_mag_left,  bt.left);
          check("peak_mag_right", peak_mag_right, bt.right);
`endif
        end
        prev_stall = peak_valid && !peak_ready;
        prev_out   = {peak_valid, peak_bin, peak_mag, peak_rank, peak_last};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n     = 1'b0;
    mag_valid = 1'b0;
    mag_in    = '0;
    bin_in    = '0;
    repeat (3) tick();
    check("rst_peak_valid", peak_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_peak_count", peak_count, 0);
    check("rst_peak_bin",   peak_bin,   0);
    check("rst_peak_mag",   peak_mag,   0);
    check("rst_peak_rank",  peak_rank,  0);
    check("rst_peak_last",  peak_last,  0);
    check("rst_overrun",    overrun,    0);
    rst_n = 1'b1;
    tick();

    // Single tone
    fill_const(28'd100);
    fm[50] = 28'd90000;
    send_frame(FFT_SIZE, 1'b0);
    drain();

    // Five peaks, K=4 keeps the largest four
    fill_const(28'd100);
    fm[10] = 28'd40000; fm[20] = 28'd70000; fm[30] = 28'd50000;
    fm[40] = 28'd90000; fm[50] = 28'd60000;
    send_frame(FFT_SIZE, 1'b0);
    drain();

    // Window edges and plateau
    fill_const(28'd100);
    fm[1]    = 28'd80000;
    fm[1023] = 28'd80000;
    fm[200]  = 28'd60000;
    fm[201]  = 28'd60000;
    send_frame(FFT_SIZE, 1'b1);
    drain();

    // Back-pressure on the first beat
    fill_const(28'd100);
    fm[100] = 28'd50000; fm[300] = 28'd70000; fm[500] = 28'd40000;
    hold_ready = 1'b1;
    send_frame(FFT_SIZE, 1'b0);
    wait_valid(ok);
    check("bp_valid_seen", ok, 1);
    repeat (5) tick();
    hold_ready = 1'b0;
    drain();

    // Below threshold: no peaks
    fill_random(1'b1);
    send_frame(FFT_SIZE, 1'b1);
    drain();

    // Aborted frame then data during REPORT
    fill_random(1'b0);
    send_frame(701, 1'b1);
    fill_const(28'd500);
    fm[600] = 28'd120000; fm[700] = 28'd99000;
    hold_ready = 1'b1;
    send_frame(FFT_SIZE, 1'b1);
    wait_valid(ok);
    check("ovr_valid_seen", ok, 1);
    check("ovr_before", overrun, 0);
    for (int i = 0; i < 3; i++) begin
      mag_valid = 1'b1;
      mag_in    = 28'd150000;
      bin_in    = '0;
      tick();
    end
    mag_valid = 1'b0;
    check("ovr_set", overrun, 1);
    hold_ready = 1'b0;
    drain();

    // Random frames
    for (int f = 0; f < 6; f++) begin
      fill_random(1'b0);
      send_frame(FFT_SIZE, 1'b1);
      drain();
    end

    check("ovr_sticky", overrun, 1);
    check("beats_left", exp_beats.size(), 0);
    check("counts_left", exp_counts.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
